djs130_tto_vwriter: RTL and testbench
=====================================

Name: djs130_tto_vwriter

Overview:
Parametrised successor to the DJS130 teletype-output (TTO) character writer.
- Accepts characters through the DJS130 device interface (DOA/start/clear, busy/done, interrupt request).
- Interprets ASCII control codes and keeps a cursor.
- Writes {attribute, char} words into the text VRAM that the tinygdu display path reads.
- Supports configurable geometry, auto-wrap, hardware scroll via a row offset, and full-screen clear.

Parameters:
COL_BITS, 7, VRAM column address width.
ROW_BITS, 5, VRAM row address width; the physical ring holds 2^ROW_BITS rows.
COLS, 80, visible columns; must be <= 2^COL_BITS.
ROWS, 25, visible rows; must be <= 2^ROW_BITS.
AUTO_WRAP, 1, 1 = a printable char in column COLS-1 is followed by CR+LF; 0 = cursor sticks at COLS-1.
ATTR_DEFAULT, 8'h07, attribute byte placed in wdata[15:8].

Ports:
clk_24m  in  1  sole clock; the VRAM write port runs on this clock.
rst_n  in  1  asynchronous active-low reset.
i_dev_doa  in  1  one-cycle strobe: latch i_dev_SR[7:0] as the pending character.
i_dev_start  in  1  one-cycle KZS strobe: set busy, clear done, start processing.
i_dev_clear  in  1  one-cycle KZC strobe: clear busy and done.
i_dev_mask  in  1  1 = interrupt masked.
i_dev_SR  in  16  device data bus.
o_dev_ZT  out  2  {done, busy}.
o_dev_ZDQQ  out  1  interrupt request = done & ~i_dev_mask.
o_vram_we  out  1  VRAM write enable, one word per cycle.
o_vram_addr  out  COL_BITS+ROW_BITS  {col, logical row}; the logical row is not yet offset.
o_vram_wdata  out  16  {attr, char}.
o_vram_yoffset  out  ROW_BITS  scroll offset; physical row = (logical row + yoffset) mod 2^ROW_BITS.
o_cur_col  out  COL_BITS  cursor column, for cursor display.
o_cur_row  out  ROW_BITS  cursor logical row.

Behaviour:
- Reset values: busy=0, done=0, we=0, addr=0, wdata=0, yoffset=0, cursor=(0,0), state=IDLE.
- Character handling: the character is i_dev_SR[6:0]; bit 7 (parity) is always masked off.
- States: IDLE -> DECODE -> {WRITE | CLEAR_LINE | CLEAR_SCR} -> FINISH -> IDLE.
- IDLE: on i_dev_start, set busy=1 and done=0, then go to DECODE next cycle.
- DECODE (1 cycle), dispatch on the character:
  - 0x20-0x7E: go to WRITE.
  - 0x0D (CR): col=0.
  - 0x0A (LF): if row<ROWS-1 then row++; else yoffset++ (wraps mod 2^ROW_BITS) and go to CLEAR_LINE for the new bottom row.
  - 0x08 (BS): col = max(col-1, 0).
  - 0x0C (FF): go to CLEAR_SCR.
  - Any other code: no effect.
- WRITE (1 cycle): we=1, addr={col,row}, wdata={ATTR_DEFAULT,char}. Then:
  - col<COLS-1: col++.
  - col==COLS-1 and AUTO_WRAP=1: col=0, then the LF action (which may enter CLEAR_LINE).
  - col==COLS-1 and AUTO_WRAP=0: col is held.
- CLEAR_LINE: COLS cycles; we=1, wdata={ATTR_DEFAULT,8'h20}, addr={c,ROWS-1} for c=0..COLS-1.
- CLEAR_SCR: ROWS*COLS cycles of the same blank write, column-fastest. yoffset=0 from the first clear cycle. At the end, cursor=(0,0).
- FINISH: busy=0, done=1; stay in IDLE until the next start.
- Latency from start to done:
  - printable: 3 cycles (no scroll);
  - CR/LF/BS: 2 cycles;
  - scroll: 3+COLS cycles;
  - FF: 2+ROWS*COLS cycles.
- Simultaneous events:
  - doa with start in the same cycle: the new data is used.
  - doa while busy: the latch updates, but the current operation uses its captured copy.
  - start while busy: ignored.
  - clear: has priority over every other event and aborts any operation. we=0 next cycle, state returns to IDLE, busy=0, done=0. Cursor and yoffset keep their current values; a partly cleared region stays partly cleared.
  - clear with start in the same cycle: clear wins.
- Asynchronous reset mid-operation: every register returns to its reset value immediately; VRAM contents are left unchanged.
- Width rules:
  - Cursor counters wrap only as stated above, never arithmetically.
  - yoffset uses modulo-2^ROW_BITS addition.
  - Column and row counters are compared against COLS-1 and ROWS-1 after width extension.

Decomposition:
- Package djs130_tto_pkg holds:
  - the state enum;
  - ASCII constants CH_CR, CH_LF, CH_BS, CH_FF, CH_SP;
  - localparams PRINT_LO=0x20 and PRINT_HI=0x7E.
- One sub-module, djs130_tto_cursor, owns the cursor and yoffset counters. Its inputs are col_inc, col_zero, col_dec, lf, home. Its outputs are at_last_col, at_last_row, scroll.
- The top level keeps the device flags, the FSM and the VRAM port.

Test Plan:
- Reset, then doa 0x00C1 + start, with default parameters -> one write: addr={0,0}, wdata=16'h0741 (parity stripped). done=1 three cycles after start; ZDQQ=1 when mask=0.
- Write 80 'X' (0x58) -> the 80th char goes to col 79. Cursor then becomes (0,1); no other writes occur.
- Cursor at row 24, send LF -> yoffset=1, then 80 consecutive writes of 16'h0720 to rows {c,24} with c=0..79. done at start+83.
- FF after yoffset=5 -> 2000 blank writes, yoffset=0, cursor=(0,0), done at start+2002.
- Assert clear midway through a scroll, then start BS at col 0 -> we drops the next cycle; busy=0 and done=0. Col stays 0 after BS; done=1 two cycles after start.
- AUTO_WRAP=0 build: write 81 chars -> the last two both land at col 79; row stays 0. Also check start while busy is ignored and mask=1 keeps ZDQQ=0 while done=1.

Source files
------------

// File: rtl/djs130_tto_pkg.sv
// Shared types and constants for the DJS130 TTO VRAM character writer.
package djs130_tto_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_WRITE,
      ST_CLEAR_LINE,
      ST_CLEAR_SCR,
      ST_FINISH
   } tto_state_e;

   localparam logic [6:0] CH_BS = 7'h08;
   localparam logic [6:0] CH_LF = 7'h0A;
   localparam logic [6:0] CH_FF = 7'h0C;
   localparam logic [6:0] CH_CR = 7'h0D;
   localparam logic [6:0] CH_SP = 7'h20;

   localparam logic [6:0] PRINT_LO = 7'h20;
   localparam logic [6:0] PRINT_HI = 7'h7E;

   // True for characters that produce a glyph write.
   function automatic logic is_print(input logic [6:0] ch);
      return (ch >= PRINT_LO) && (ch <= PRINT_HI);
   endfunction

endpackage

// File: rtl/djs130_tto_cursor.sv
// Cursor (col,row) and scroll offset counters for the TTO writer.
// scroll_o is a one-cycle pulse the cycle after an LF on the bottom row,
// telling the FSM that the new bottom row must be blanked.
module djs130_tto_cursor
   import djs130_tto_pkg::*;
#(
   parameter int COL_BITS = 7,
   parameter int ROW_BITS = 5,
   parameter int COLS     = 80,
   parameter int ROWS     = 25
) (
   input  logic                clk_24m,
   input  logic                rst_n,
   input  logic                col_inc_i,
   input  logic                col_zero_i,
   input  logic                col_dec_i,
   input  logic                lf_i,
   input  logic                home_i,
   input  logic                yoff_zero_i,
   output logic [COL_BITS-1:0] col_o,
   output logic [ROW_BITS-1:0] row_o,
   output logic [ROW_BITS-1:0] yoffset_o,
   output logic                at_last_col_o,
   output logic                at_last_row_o,
   output logic                scroll_o
);

   logic [COL_BITS-1:0] col_q, col_d;
   logic [ROW_BITS-1:0] row_q, row_d;
   logic [ROW_BITS-1:0] yoff_q, yoff_d;
   logic                scroll_q, scroll_d;

   // Compare in 32 bits so COLS/ROWS equal to the full ring size stay exact.
   assign at_last_col_o = (32'(col_q) == 32'(COLS - 1));
   assign at_last_row_o = (32'(row_q) == 32'(ROWS - 1));

   // Next cursor/offset: column ops are exclusive, LF may scroll, home wins.
   always_comb begin
      col_d    = col_q;
      row_d    = row_q;
      yoff_d   = yoff_q;
      scroll_d = 1'b0;
      if (col_zero_i)
         col_d = '0;
      else if (col_inc_i && !at_last_col_o)
         col_d = col_q + COL_BITS'(1);
      else if (col_dec_i && (col_q != '0))
         col_d = col_q - COL_BITS'(1);
      if (lf_i) begin
         if (at_last_row_o) begin
            yoff_d   = yoff_q + ROW_BITS'(1);
            scroll_d = 1'b1;
         end else begin
            row_d = row_q + ROW_BITS'(1);
         end
      end
      if (yoff_zero_i)
         yoff_d = '0;
      if (home_i) begin
         col_d = '0;
         row_d = '0;
      end
   end

   // Counter registers.
   always_ff @(posedge clk_24m or negedge rst_n) begin
      if (!rst_n) begin
         col_q    <= '0;
         row_q    <= '0;
         yoff_q   <= '0;
         scroll_q <= 1'b0;
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         yoff_q   <= yoff_d;
         scroll_q <= scroll_d;
      end
   end

   assign col_o     = col_q;
   assign row_o     = row_q;
   assign yoffset_o = yoff_q;
   assign scroll_o  = scroll_q;

endmodule

// File: rtl/djs130_tto_vwriter.sv
// DJS130 teletype-output writer: device flags, control-code FSM and a
// registered VRAM write port producing {attr,char} words.
module djs130_tto_vwriter
   import djs130_tto_pkg::*;
#(
   parameter int         COL_BITS     = 7,
   parameter int         ROW_BITS     = 5,
   parameter int         COLS         = 80,
   parameter int         ROWS         = 25,
   parameter bit         AUTO_WRAP    = 1'b1,
   parameter logic [7:0] ATTR_DEFAULT = 8'h07
) (
   input  logic                         clk_24m,
   input  logic                         rst_n,
   input  logic                         i_dev_doa,
   input  logic                         i_dev_start,
   input  logic                         i_dev_clear,
   input  logic                         i_dev_mask,
   input  logic [15:0]                  i_dev_SR,
   output logic [1:0]                   o_dev_ZT,
   output logic                         o_dev_ZDQQ,
   output logic                         o_vram_we,
   output logic [COL_BITS+ROW_BITS-1:0] o_vram_addr,
   output logic [15:0]                  o_vram_wdata,
   output logic [ROW_BITS-1:0]          o_vram_yoffset,
   output logic [COL_BITS-1:0]          o_cur_col,
   output logic [ROW_BITS-1:0]          o_cur_row
);

   localparam logic [15:0]         BLANK    = {ATTR_DEFAULT, 1'b0, CH_SP};
   localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

   tto_state_e state_q, state_d;
   logic       busy_q, busy_d, done_q, done_d;
   logic [6:0] pend_q, pend_d;   // most recent DOA character
   logic [6:0] cap_q, cap_d;     // character owned by the running operation
   logic       we_q, we_d;
   logic [COL_BITS+ROW_BITS-1:0] addr_q, addr_d;
   logic [15:0]                  wdata_q, wdata_d;
   logic [COL_BITS-1:0]          ccol_q, ccol_d;   // clear-sweep column
   logic [ROW_BITS-1:0]          crow_q, crow_d;   // clear-sweep row

   logic                col_inc, col_zero, col_dec, lf, home, yoff_zero;
   logic [COL_BITS-1:0] cur_col;
   logic [ROW_BITS-1:0] cur_row, yoff;
   logic                at_last_col, at_last_row, scroll;
   logic                ccol_last, crow_last;
   logic                unused_sr;

   assign unused_sr = ^i_dev_SR[15:7];
   assign ccol_last = (32'(ccol_q) == 32'(COLS - 1));
   assign crow_last = (32'(crow_q) == 32'(ROWS - 1));

   djs130_tto_cursor #(
      .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .COLS(COLS), .ROWS(ROWS)
   ) u_cursor (
      .clk_24m      (clk_24m),
      .rst_n        (rst_n),
      .col_inc_i    (col_inc),
      .col_zero_i   (col_zero),
      .col_dec_i    (col_dec),
      .lf_i         (lf),
      .home_i       (home),
      .yoff_zero_i  (yoff_zero),
      .col_o        (cur_col),
      .row_o        (cur_row),
      .yoffset_o    (yoff),
      .at_last_col_o(at_last_col),
      .at_last_row_o(at_last_row),
      .scroll_o     (scroll)
   );

   // FSM next state, device flags, cursor commands and VRAM write word.
   // A scroll is seen in FINISH (one cycle after the LF) and detours
   // through CLEAR_LINE before the operation completes.
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pend_d    = i_dev_doa ? i_dev_SR[6:0] : pend_q;
      cap_d     = cap_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      ccol_d    = ccol_q;
      crow_d    = crow_q;
      col_inc   = 1'b0;
      col_zero  = 1'b0;
      col_dec   = 1'b0;
      lf        = 1'b0;
      home      = 1'b0;
      yoff_zero = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_dev_start) begin
               busy_d  = 1'b1;
               done_d  = 1'b0;
               cap_d   = i_dev_doa ? i_dev_SR[6:0] : pend_q;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_d = ST_FINISH;
            if (is_print(cap_q)) begin
               state_d = ST_WRITE;
            end else begin
               case (cap_q)
                  CH_CR: col_zero = 1'b1;
                  CH_LF: lf       = 1'b1;
                  CH_BS: col_dec  = 1'b1;
                  CH_FF: begin
                     yoff_zero = 1'b1;
                     ccol_d    = '0;
                     crow_d    = '0;
                     state_d   = ST_CLEAR_SCR;
                  end
                  default: ;
               endcase
            end
         end
         ST_WRITE: begin
            we_d    = 1'b1;
            addr_d  = {cur_col, cur_row};
            wdata_d = {ATTR_DEFAULT, 1'b0, cap_q};
            state_d = ST_FINISH;
            if (!at_last_col) begin
               col_inc = 1'b1;
            end else if (AUTO_WRAP) begin
               col_zero = 1'b1;
               lf       = 1'b1;
            end
         end
         ST_CLEAR_LINE: begin
            we_d    = 1'b1;
            addr_d  = {ccol_q, LAST_ROW};
            wdata_d = BLANK;
            if (ccol_last)
               state_d = ST_FINISH;
            else
               ccol_d = ccol_q + COL_BITS'(1);
         end
         ST_CLEAR_SCR: begin
            we_d    = 1'b1;
            addr_d  = {ccol_q, crow_q};
            wdata_d = BLANK;
            if (ccol_last) begin
               ccol_d = '0;
               if (crow_last) begin
                  home    = 1'b1;
                  state_d = ST_FINISH;
               end else begin
                  crow_d = crow_q + ROW_BITS'(1);
               end
            end else begin
               ccol_d = ccol_q + COL_BITS'(1);
            end
         end
         ST_FINISH: begin
            if (scroll) begin
               ccol_d  = '0;
               state_d = ST_CLEAR_LINE;
            end else begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Clear aborts everything; cursor and offset keep their values.
      if (i_dev_clear) begin
         state_d   = ST_IDLE;
         busy_d    = 1'b0;
         done_d    = 1'b0;
         we_d      = 1'b0;
         col_inc   = 1'b0;
         col_zero  = 1'b0;
         col_dec   = 1'b0;
         lf        = 1'b0;
         home      = 1'b0;
         yoff_zero = 1'b0;
      end
   end

   // State, flag and VRAM port registers.
   always_ff @(posedge clk_24m or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pend_q  <= '0;
         cap_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ccol_q  <= '0;
         crow_q  <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pend_q  <= pend_d;
         cap_q   <= cap_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ccol_q  <= ccol_d;
         crow_q  <= crow_d;
      end
   end

   assign o_dev_ZT       = {done_q, busy_q};
   assign o_dev_ZDQQ     = done_q & ~i_dev_mask;
   assign o_vram_we      = we_q;
   assign o_vram_addr    = addr_q;
   assign o_vram_wdata   = wdata_q;
   assign o_vram_yoffset = yoff;
   assign o_cur_col      = cur_col;
   assign o_cur_row      = cur_row;

endmodule

// File: tb/tb_djs130_tto_vwriter.sv
// Randomized self-checking bench: dut 0 = default build, dut 1 = AUTO_WRAP=0.
module tb_djs130_tto_vwriter;

   localparam int COLS = 80;
   localparam int ROWS = 25;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  doa = '0, start = '0, clr = '0, mask = '0;
   logic [15:0] sr [2];
   logic [1:0]  zt [2];
   logic [1:0]  zdqq, we;
   logic [11:0] addr [2];
   logic [15:0] wdata [2];
   logic [4:0]  yoff [2];
   logic [6:0]  ccol [2];
   logic [4:0]  crow [2];

   always #5 clk = ~clk;

   djs130_tto_vwriter u_dut_a (
      .clk_24m(clk), .rst_n(rst_n), .i_dev_doa(doa[0]), .i_dev_start(start[0]),
      .i_dev_clear(clr[0]), .i_dev_mask(mask[0]), .i_dev_SR(sr[0]),
      .o_dev_ZT(zt[0]), .o_dev_ZDQQ(zdqq[0]), .o_vram_we(we[0]),
      .o_vram_addr(addr[0]), .o_vram_wdata(wdata[0]), .o_vram_yoffset(yoff[0]),
      .o_cur_col(ccol[0]), .o_cur_row(crow[0]));

   djs130_tto_vwriter #(.AUTO_WRAP(1'b0)) u_dut_b (
      .clk_24m(clk), .rst_n(rst_n), .i_dev_doa(doa[1]), .i_dev_start(start[1]),
      .i_dev_clear(clr[1]), .i_dev_mask(mask[1]), .i_dev_SR(sr[1]),
      .o_dev_ZT(zt[1]), .o_dev_ZDQQ(zdqq[1]), .o_vram_we(we[1]),
      .o_vram_addr(addr[1]), .o_vram_wdata(wdata[1]), .o_vram_yoffset(yoff[1]),
      .o_cur_col(ccol[1]), .o_cur_row(crow[1]));

   int n_cmp = 0, n_bad = 0;
   int m_col [2], m_row [2], m_yoff [2];
   bit aw [2] = '{1'b1, 1'b0};
   logic [27:0] exp_q[$], got0[$], got1[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // VRAM write monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (we[0] === 1'b1) got0.push_back({addr[0], wdata[0]});
      if (we[1] === 1'b1) got1.push_back({addr[1], wdata[1]});
   end

   // Reference: line feed on the screen model; scrolling blanks the bottom row.
   task automatic m_lf(input int w, output bit scr);
      scr = 1'b0;
      if (m_row[w] < ROWS - 1) m_row[w]++;
      else begin
         m_yoff[w] = (m_yoff[w] + 1) % 32;
         scr = 1'b1;
         for (int c = 0; c < COLS; c++) exp_q.push_back({7'(c), 5'(ROWS - 1), 16'h0720});
      end
   endtask

   // Reference: effect of one character, expected writes and start->done cycles.
   task automatic model(input int w, input logic [6:0] ch, output int lat);
      bit scr = 1'b0;
      lat = 2;
      if (ch >= 7'h20 && ch <= 7'h7E) begin
         exp_q.push_back({7'(m_col[w]), 5'(m_row[w]), 8'h07, 1'b0, ch});
         lat = 3;
         if (m_col[w] < COLS - 1) m_col[w]++;
         else if (aw[w]) begin m_col[w] = 0; m_lf(w, scr); end
      end else if (ch == 7'h0D) m_col[w] = 0;
      else if (ch == 7'h0A) m_lf(w, scr);
      else if (ch == 7'h08) m_col[w] = (m_col[w] > 0) ? m_col[w] - 1 : 0;
      else if (ch == 7'h0C) begin
         m_yoff[w] = 0;
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_q.push_back({7'(c), 5'(r), 16'h0720});
         m_col[w] = 0; m_row[w] = 0;
         lat = 2 + ROWS * COLS;
      end
      if (scr) lat += COLS + 1;
   endtask

   // One complete operation on dut w, with noise strobes while it is busy.
   task automatic send(input int w, input logic [7:0] data);
      int lat, n;
      logic [27:0] gq[$];
      exp_q.delete(); got0.delete(); got1.delete();
      model(w, data[6:0], lat);
      sr[w] = {8'($urandom), data};
      doa[w] = 1'b1; start[w] = 1'b1;
      tick();
      doa[w] = 1'b0; start[w] = 1'b0;
      chk("busy", 32'(zt[w]), 32'h1);
      n = 0;
      while (zt[w][1] !== 1'b1 && n < 5000) begin
         if (n == 0 && $urandom_range(1, 0) == 1) begin
            doa[w] = 1'b1; start[w] = 1'b1; sr[w] = 16'($urandom);
         end
         tick();
         doa[w] = 1'b0; start[w] = 1'b0;
         n++;
      end
      chk("latency", n, lat);
      gq = (w == 0) ? got0 : got1;
      chk("nwrites", gq.size(), exp_q.size());
      for (int i = 0; i < gq.size() && i < exp_q.size(); i++) chk("write", gq[i], exp_q[i]);
      chk("col", 32'(ccol[w]), m_col[w]);
      chk("row", 32'(crow[w]), m_row[w]);
      chk("yoff", 32'(yoff[w]), m_yoff[w]);
      chk("zt_done", 32'(zt[w]), 32'h2);
      chk("zdqq", 32'(zdqq[w]), 32'(!mask[w]));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      for (int w = 0; w < 2; w++) begin
         chk("rst_zt", 32'(zt[w]), 0);
         chk("rst_we", 32'(we[w]), 0);
         chk("rst_addr", 32'(addr[w]), 0);
         chk("rst_wdata", 32'(wdata[w]), 0);
         chk("rst_yoff", 32'(yoff[w]), 0);
         chk("rst_cur", {ccol[w], crow[w]}, 0);
         m_col[w] = 0; m_row[w] = 0; m_yoff[w] = 0;
      end
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [7:0] ch;
      int r;
      sr[0] = '0; sr[1] = '0;
      #2;
      do_reset();

      // Parity bit stripped, single write, interrupt raised.
      send(0, 8'hC1);

      // Asynchronous reset in the middle of a full-screen clear.
      sr[0] = 16'h000C; doa[0] = 1'b1; start[0] = 1'b1;
      tick();
      doa[0] = 1'b0; start[0] = 1'b0;
      repeat (10) tick();
      do_reset();

      // A full line of X: wrap to (0,1) with no extra writes.
      for (int i = 0; i < COLS; i++) send(0, 8'h58);
      // Down to the bottom row, then scrolls.
      for (int i = 0; i < ROWS - 2; i++) send(0, 8'h0A);
      for (int i = 0; i < 5; i++) send(0, 8'h0A);
      chk("yoff5", 32'(yoff[0]), 5);
      send(0, 8'h0C);

      // Clear in the middle of a scroll.
      for (int i = 0; i < ROWS - 1; i++) send(0, 8'h0A);
      sr[0] = 16'h000A; doa[0] = 1'b1; start[0] = 1'b1;
      tick();
      doa[0] = 1'b0; start[0] = 1'b0;
      m_yoff[0] = (m_yoff[0] + 1) % 32;
      repeat (20) tick();
      chk("midclr_we", 32'(we[0]), 1);
      clr[0] = 1'b1;
      tick();
      clr[0] = 1'b0;
      chk("abort_we", 32'(we[0]), 0);
      chk("abort_zt", 32'(zt[0]), 0);
      chk("abort_yoff", 32'(yoff[0]), m_yoff[0]);
      chk("abort_row", 32'(crow[0]), m_row[0]);
      tick();
      chk("abort_idle_we", 32'(we[0]), 0);
      send(0, 8'h0D);
      send(0, 8'h08);

      // Randomized character stream.
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(99);
         if (r < 70)      ch = 8'($urandom_range(8'h7E, 8'h20));
         else if (r < 80) ch = 8'h0A;
         else if (r < 87) ch = 8'h0D;
         else if (r < 93) ch = 8'h08;
         else if (r < 94) ch = 8'h0C;
         else if (r < 97) ch = 8'h1B;
         else             ch = 8'h7F;
         ch[7] = 1'($urandom);
         mask[0] = 1'($urandom);
         send(0, ch);
      end

      // No-wrap build: cursor sticks at the last column, masked interrupt.
      mask[1] = 1'b1;
      for (int i = 0; i < COLS + 1; i++) send(1, 8'h40 + 8'(i % 26));
      chk("b_col", 32'(ccol[1]), COLS - 1);
      chk("b_row", 32'(crow[1]), 0);
      chk("b_zdqq_masked", 32'(zdqq[1]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
